dtc_seq_eval: RTL and testbench
===============================

DTC_SEQ_EVAL -- requirements
Module: dtc_seq_eval

Interface
REQ-001 Parameter IN_W, default 12, feature vector width in bits.
REQ-002 Parameter OUT_W, default 3, class code width in bits.
REQ-003 Parameter NODES, default 256, node table depth; AW = clog2(NODES), FW = clog2(IN_W).
REQ-004 Parameter DEPTH_MAX, default 16, maximum internal nodes walked per query; used only with DTC_STEP_LIMIT_EN.
REQ-005 clk  in  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 in_valid  in  1  query present.
REQ-008 in_data  in  IN_W  feature vector.
REQ-009 in_ready  out  1  block can accept a query.
REQ-010 out_valid  out  1  result present.
REQ-011 out_class  out  OUT_W  class code.
REQ-012 out_err  out  1  walk aborted by step limit.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 cfg_we  in  1  node table write strobe.
REQ-015 cfg_addr  in  AW  node table write address.
REQ-016 cfg_data  in  1+FW+2*AW+OUT_W  node word: [0] leaf; [FW:1] feature index; next AW bits child0; next AW bits child1; top OUT_W bits class.
REQ-017 cfg_err  out  1  one-cycle pulse when a write is dropped.

Function
REQ-018 The FSM SHALL have states IDLE, WALK and DONE; in_ready = (state == IDLE).
REQ-019 In IDLE, in_valid=1 SHALL register in_data, set ptr=0 and step=0, and move to WALK.
REQ-020 In WALK, each cycle SHALL read node[ptr] combinationally; if leaf=1: latch class into out_class, clear out_err, move to DONE.
REQ-021 In WALK with leaf=0, ptr SHALL load child1 if in_data_q[feature]=1, else child0; step increments by 1.
REQ-022 A feature index >= IN_W SHALL read as bit value 0.
REQ-023 Latency: a query accepted in cycle T whose path has k internal nodes SHALL assert out_valid in cycle T+k+2.
REQ-024 out_valid SHALL be 1 exactly in DONE; out_class and out_err SHALL hold stable until out_ready=1.
REQ-025 In DONE with out_ready=1, the FSM SHALL return to IDLE; the next query is accepted no earlier than the following cycle.
REQ-026 cfg_we in IDLE SHALL write node[cfg_addr] at that edge.
REQ-027 cfg_we in WALK or DONE SHALL be dropped, with cfg_err=1 for one cycle; the in-flight walk is unaffected.
REQ-028 cfg_we and in_valid in the same IDLE cycle: the write SHALL commit and the query SHALL be accepted; the walk then sees the new contents.
REQ-029 cfg_addr >= NODES SHALL be dropped with cfg_err=1.
REQ-030 A child pointer >= NODES SHALL be treated as a leaf with class 0.

Reset
REQ-031 While rst_n=0: state=IDLE, out_valid=0, out_class=0, out_err=0, cfg_err=0, ptr=0, step=0; in_ready=1 after rst_n rises.
REQ-032 Node table contents SHALL reset to all-zero words, so node 0 is an internal node with feature 0 and both children pointing to 0.
REQ-033 Reset mid-walk or in DONE SHALL abandon the query with no result emitted.

Configuration
REQ-034 Macro DTC_STEP_LIMIT_EN defined: in WALK, when step == DEPTH_MAX and node[ptr] is not a leaf, the FSM SHALL go to DONE with out_class=0 and out_err=1.
REQ-035 Macro DTC_STEP_LIMIT_EN undefined: no step counter, out_err SHALL be tied 0, and a cyclic table walks until reset.

Verification
REQ-036 Node0 = leaf class 5; query accepted at T -> out_valid at T+2, out_class=5, out_err=0.
REQ-037 Node0 internal, feature 9, child0=1, child1=2; node1 leaf 3, node2 leaf 6; in_data bit9=1 -> out_class=6 at T+3; bit9=0 -> out_class=3.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> out_valid and out_class stable, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-039 cfg_we during WALK -> cfg_err pulse of 1 cycle; table unchanged; walk result unchanged.
REQ-040 After reset (node0 self-loop), with DTC_STEP_LIMIT_EN and DEPTH_MAX=16 -> out_valid at T+18 with out_err=1, out_class=0; without the macro -> no out_valid.
REQ-041 Assert rst_n=0 mid-walk -> out_valid=0 immediately, in_ready=1 after release, and no stale result is emitted.

Source files
------------

// File: rtl/dtc_seq_eval_if.sv
// Query/result handshake bundle for dtc_seq_eval.
// A transfer happens on a rising edge where valid and ready are both 1; the
// source holds valid and its payload stable until that edge.
interface dtc_seq_eval_if #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 3
);
  logic             in_valid;
  logic [IN_W-1:0]  in_data;
  logic             in_ready;
  logic             out_valid;
  logic [OUT_W-1:0] out_class;
  logic             out_err;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_class, out_err
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_class, out_err
  );
endinterface

// File: rtl/dtc_seq_eval.sv
// Sequential decision-tree evaluator: walks a writable node table one node per cycle.
// Optional macro DTC_STEP_LIMIT_EN aborts walks longer than DEPTH_MAX internal nodes.
module dtc_seq_eval #(
  parameter int IN_W      = 12,
  parameter int OUT_W     = 3,
  parameter int NODES     = 256,
  parameter int DEPTH_MAX = 16,
  localparam int AW = $clog2(NODES),
  localparam int FW = $clog2(IN_W),
  localparam int CW = 1 + FW + 2*AW + OUT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  dtc_seq_eval_if.slave q,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic          cfg_err,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [AW-1:0]    ptr;
  logic [IN_W-1:0]  data_q;
  logic [OUT_W-1:0] class_q;
  logic [CW-1:0]    mem [NODES];

  logic             ptr_ok;
  logic [CW-1:0]    node_w;
  logic             node_leaf;
  logic [FW-1:0]    node_feat;
  logic [AW-1:0]    node_c0;
  logic [AW-1:0]    node_c1;
  logic [OUT_W-1:0] node_cls;
  logic             feat_bit;
  logic             cfg_ok;
  logic             cfg_drop;
  logic             step_hit;

`ifdef DTC_STEP_LIMIT_EN
  localparam int STEP_W = $clog2(DEPTH_MAX + 1);
  logic [STEP_W-1:0] step;
  logic              err_q;
`else
  logic unused_depth;
  assign unused_depth = (DEPTH_MAX == 0);
`endif

  // An out-of-range pointer decodes as a leaf of class 0.
  always_comb begin
    ptr_ok    = (int'(ptr) < NODES);
    node_w    = ptr_ok ? mem[ptr] : '0;
    node_leaf = node_w[0] | ~ptr_ok;
    node_feat = node_w[FW:1];
    node_c0   = node_w[FW+AW -: AW];
    node_c1   = node_w[FW+2*AW -: AW];
    node_cls  = ptr_ok ? node_w[CW-1 -: OUT_W] : '0;
    feat_bit  = (int'(node_feat) < IN_W) ? data_q[node_feat] : 1'b0;
    cfg_ok    = cfg_we && (state == IDLE) && (int'(cfg_addr) < NODES);
    cfg_drop  = cfg_we && !cfg_ok;
`ifdef DTC_STEP_LIMIT_EN
    step_hit  = (step == STEP_W'(DEPTH_MAX));
`else
    step_hit  = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NODES; i++) mem[i] <= '0;
    end else if (cfg_ok) begin
      mem[cfg_addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      data_q  <= '0;
      class_q <= '0;
      cfg_err <= 1'b0;
`ifdef DTC_STEP_LIMIT_EN
      step    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      cfg_err <= cfg_drop;
      case (state)
        IDLE: begin
          if (q.in_valid) begin
            data_q <= q.in_data;
            ptr    <= '0;
`ifdef DTC_STEP_LIMIT_EN
            step   <= '0;
`endif
            state  <= WALK;
          end
        end
        WALK: begin
          if (node_leaf) begin
            class_q <= node_cls;
`ifdef DTC_STEP_LIMIT_EN
            err_q   <= 1'b0;
`endif
            state   <= DONE;
          end else if (step_hit) begin
            class_q <= '0;
`ifdef DTC_STEP_LIMIT_EN
            err_q   <= 1'b1;
`endif
            state   <= DONE;
          end else begin
            ptr <= feat_bit ? node_c1 : node_c0;
`ifdef DTC_STEP_LIMIT_EN
            step <= step + 1'b1;
`endif
          end
        end
        DONE: begin
          if (q.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign q.in_ready  = (state == IDLE);
  assign q.out_valid = (state == DONE);
  assign q.out_class = class_q;
  assign dbg_state   = state;
`ifdef DTC_STEP_LIMIT_EN
  assign q.out_err   = err_q;
`else
  assign q.out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dtc_seq_eval.sv
// Self-checking bench for dtc_seq_eval: table mirror + walk model, result scoreboard.
module tb_dtc_seq_eval;
  localparam int IN_W      = 12;
  localparam int OUT_W     = 3;
  localparam int NODES     = 200;
  localparam int DEPTH_MAX = 16;
  localparam int AW = $clog2(NODES);
  localparam int FW = $clog2(IN_W);
  localparam int CW = 1 + FW + 2*AW + OUT_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [CW-1:0] cfg_data = '0;
  logic          cfg_err;
  logic [1:0]    dbg_state;
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;

  logic [OUT_W:0] exp_q[$];
  logic [CW-1:0]  tb_mem [NODES];

  dtc_seq_eval_if #(.IN_W(IN_W), .OUT_W(OUT_W)) qif();

  dtc_seq_eval #(.IN_W(IN_W), .OUT_W(OUT_W), .NODES(NODES), .DEPTH_MAX(DEPTH_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .q(qif),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [CW-1:0] mk_node(input bit leaf, input int feat, input int c0,
                                            input int c1, input int cls);
    logic [CW-1:0] w;
    w = '0;
    w[0] = leaf;
    w[FW:1] = feat[FW-1:0];
    w[FW+AW -: AW] = c0[AW-1:0];
    w[FW+2*AW -: AW] = c1[AW-1:0];
    w[CW-1 -: OUT_W] = cls[OUT_W-1:0];
    return w;
  endfunction

  function automatic void model_walk(input logic [IN_W-1:0] d, output logic [OUT_W-1:0] cls,
                                     output logic err, output int k);
    int p;
    int f;
    logic b;
    logic [CW-1:0] w;
    p = 0; k = 0; cls = '0; err = 1'b0;
    for (int it = 0; it < 64; it++) begin
      if (p >= NODES) return;
      w = tb_mem[p];
      if (w[0]) begin
        cls = w[CW-1 -: OUT_W];
        return;
      end
`ifdef DTC_STEP_LIMIT_EN
      if (k == DEPTH_MAX) begin
        err = 1'b1;
        return;
      end
`endif
      f = int'(w[FW:1]);
      b = 1'b0;
      if (f < IN_W) b = d[f];
      p = b ? int'(w[FW+2*AW -: AW]) : int'(w[FW+AW -: AW]);
      k++;
    end
    k = -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    qif.in_valid = 1'b0; qif.in_data = '0; qif.out_ready = 1'b0;
    cfg_we = 1'b0;
    for (int i = 0; i < NODES; i++) tb_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (qif.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic cfg_write(input logic [AW-1:0] a, input logic [CW-1:0] w);
    logic e;
    wait_idle();
    e = (int'(a) >= NODES);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = w;
    if (!e) tb_mem[a] = w;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    total++;
    if (cfg_err !== e) begin
      bad++; $display("FAIL cfg_err_after_write addr=%0d got=%b want=%b", a, cfg_err, e);
    end
  endtask

  // One query end to end; optional config write in the accept cycle or first walk cycle.
  task automatic send_query(input logic [IN_W-1:0] d, input int hold, input bit cfg_same,
                            input bit cfg_mid, input logic [AW-1:0] ca, input logic [CW-1:0] cd);
    logic [OUT_W-1:0] cls;
    logic err;
    logic [OUT_W:0] e;
    logic [OUT_W-1:0] seen;
    int k, t, n;
    wait_idle();
    if (cfg_same) begin
      cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
      if (int'(ca) < NODES) tb_mem[ca] = cd;
    end
    model_walk(d, cls, err, k);
    exp_q.push_back({err, cls});
    qif.in_valid = 1'b1; qif.in_data = d;
    t = cyc;
    @(posedge clk); #1;
    qif.in_valid = 1'b0; cfg_we = 1'b0;
    if (cfg_mid) begin
      cfg_we = 1'b1; cfg_addr = ca; cfg_data = cd;
      @(posedge clk); #1;
      cfg_we = 1'b0;
      total++;
      if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse got=%b want=1", cfg_err); end
      @(posedge clk); #1;
      total++;
      if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_one_cycle got=%b want=0", cfg_err); end
    end
    n = 0;
    while (qif.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (qif.out_valid !== 1'b1) begin
      bad++; $display("FAIL out_valid_timeout data=%h", d);
      void'(exp_q.pop_front());
      return;
    end
    total++;
    if (cyc != t + k + 2) begin
      bad++; $display("FAIL latency data=%h got=T+%0d want=T+%0d", d, cyc - t, k + 2);
    end
    e = exp_q.pop_front();
    total++;
    if (qif.out_class !== e[OUT_W-1:0]) begin
      bad++; $display("FAIL out_class data=%h got=%0d want=%0d", d, qif.out_class, e[OUT_W-1:0]);
    end
    total++;
    if (qif.out_err !== e[OUT_W]) begin
      bad++; $display("FAIL out_err data=%h got=%b want=%b", d, qif.out_err, e[OUT_W]);
    end
    seen = qif.out_class;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      total++;
      if (qif.out_valid !== 1'b1 || qif.out_class !== seen || qif.in_ready !== 1'b0) begin
        bad++; $display("FAIL hold_stable cycle=%0d valid=%b class=%0d ready=%b want 1/%0d/0",
                        h, qif.out_valid, qif.out_class, qif.in_ready, seen);
      end
    end
    qif.out_ready = 1'b1;
    @(posedge clk); #1;
    qif.out_ready = 1'b0;
    total++;
    if (qif.in_ready !== 1'b1 || qif.out_valid !== 1'b0) begin
      bad++; $display("FAIL return_idle ready=%b valid=%b want 1/0", qif.in_ready, qif.out_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (qif.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", qif.in_ready); end
    total++;
    if (qif.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", qif.out_valid); end
    total++;
    if (qif.out_class !== '0) begin bad++; $display("FAIL rst_out_class got=%0d want=0", qif.out_class); end
    total++;
    if (qif.out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%b want=0", qif.out_err); end
    total++;
    if (cfg_err !== 1'b0) begin bad++; $display("FAIL rst_cfg_err got=%b want=0", cfg_err); end
    total++;
    if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d want=0", dbg_state); end
  endtask

  task automatic test_leaf_root();
    cfg_write(8'd0, mk_node(1, 0, 0, 0, 5));
    send_query(12'h000, 0, 0, 0, '0, '0);
  endtask

  task automatic test_two_level();
    cfg_write(8'd0, mk_node(0, 9, 1, 2, 0));
    cfg_write(8'd1, mk_node(1, 0, 0, 0, 3));
    cfg_write(8'd2, mk_node(1, 0, 0, 0, 6));
    send_query(12'h200, 0, 0, 0, '0, '0);
    send_query(12'hDFF, 0, 0, 0, '0, '0);
  endtask

  task automatic test_hold();
    send_query(12'h200, 5, 0, 0, '0, '0);
  endtask

  task automatic test_cfg_during_walk();
    cfg_write(8'd0, mk_node(0, 0, 1, 1, 0));
    cfg_write(8'd1, mk_node(0, 0, 2, 2, 0));
    cfg_write(8'd2, mk_node(0, 0, 3, 3, 0));
    cfg_write(8'd3, mk_node(1, 0, 0, 0, 6));
    send_query(12'h000, 0, 0, 1, 8'd3, mk_node(1, 0, 0, 0, 1));
    send_query(12'h001, 0, 0, 0, '0, '0);
  endtask

  task automatic test_boundaries();
    cfg_write(8'd250, mk_node(1, 0, 0, 0, 7));
    cfg_write(8'd0, mk_node(0, 13, 1, 2, 0));
    cfg_write(8'd1, mk_node(1, 0, 0, 0, 2));
    cfg_write(8'd2, mk_node(1, 0, 0, 0, 7));
    send_query(12'hFFF, 0, 0, 0, '0, '0);
    cfg_write(8'd0, mk_node(0, 0, 1, 250, 0));
    send_query(12'h001, 0, 0, 0, '0, '0);
    send_query(12'h000, 0, 0, 0, '0, '0);
  endtask

  task automatic test_same_cycle();
    send_query(12'h123, 0, 1, 0, 8'd0, mk_node(1, 0, 0, 0, 4));
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 15; i++)
      cfg_write(8'(i), mk_node(0, $urandom_range(0, 15), 2*i + 1, 2*i + 2, 0));
    for (int i = 15; i < 31; i++)
      cfg_write(8'(i), mk_node(1, 0, 0, 0, $urandom_range(0, 7)));
    for (int i = 0; i < 12; i++)
      send_query(12'($urandom_range(0, 4095)), $urandom_range(0, 2), 0, 0, '0, '0);
  endtask

  task automatic test_step_limit();
    int n;
    do_reset();
`ifdef DTC_STEP_LIMIT_EN
    send_query(12'hABC, 0, 0, 0, '0, '0);
`else
    qif.in_valid = 1'b1; qif.in_data = 12'hABC;
    @(posedge clk); #1;
    qif.in_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (qif.out_valid === 1'b1) n++;
    end
    total++;
    if (n != 0) begin bad++; $display("FAIL cyclic_no_result got=%0d valid cycles want=0", n); end
`endif
  endtask

  task automatic test_mid_reset();
    int n;
    do_reset();
    qif.in_valid = 1'b1; qif.in_data = 12'h055;
    @(posedge clk); #1;
    qif.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (qif.out_valid !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL midreset_async valid=%b state=%0d want 0/0", qif.out_valid, dbg_state);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (qif.in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", qif.in_ready); end
    qif.out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (qif.out_valid === 1'b1) n++;
    end
    qif.out_ready = 1'b0;
    total++;
    if (n != 0) begin bad++; $display("FAIL midreset_stale got=%0d valid cycles want=0", n); end
  endtask

  initial begin
    qif.in_valid = 1'b0; qif.in_data = '0; qif.out_ready = 1'b0;
    test_reset();
    test_leaf_root();
    test_two_level();
    test_hold();
    test_cfg_during_walk();
    test_boundaries();
    test_same_cycle();
    test_back_to_back();
    test_step_limit();
    test_mid_reset();
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
endmodule
